// File: rtl/hazard_scoreboard.sv
// Hazard/forwarding controller for the decode stage: tracks in-flight destination
// writes across DEPTH post-decode stages, picks per-operand forwarding sources and detects load-use stalls.
module hazard_scoreboard #(
  parameter int ADDR_W         = 3,
  parameter int NSRC           = 2,
  parameter int DEPTH          = 3,
  parameter int LOAD_STAGE     = 2,
  parameter int RF_WRITE_FIRST = 0,
  parameter int CNT_W          = 16,
  parameter int SEL_W          = $clog2(DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    id_valid,
  input  logic [NSRC*ADDR_W-1:0]  id_src_addr,
  input  logic [NSRC-1:0]         id_src_used,
  input  logic [ADDR_W-1:0]       id_dst_addr,
  input  logic                    id_reg_write,
  input  logic                    id_mem_read,
  input  logic                    flush_in,
  output logic                    stall,
  output logic [NSRC*SEL_W-1:0]   fwd_sel,
  output logic [CNT_W-1:0]        stall_cnt
);

  // With a write-first regfile the oldest stage is already visible through the regfile read.
  localparam int MATCH_TOP = (RF_WRITE_FIRST != 0) ? DEPTH - 1 : DEPTH;

  logic [DEPTH:1]    ent_v;
  logic [DEPTH:1]    ent_rw;
  logic [DEPTH:1]    ent_ld;
  logic [ADDR_W-1:0] ent_dst [1:DEPTH];
  logic              issue;
  logic              hazard;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  assign issue = id_valid & ~stall & ~flush_in;

  // Stage boundary: decode -> stage 1, then stage k-1 -> stage k
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ent_v  <= '0;
      ent_rw <= '0;
      ent_ld <= '0;
    end else begin
      ent_v[1]  <= issue;
      ent_rw[1] <= issue & id_reg_write;
      ent_ld[1] <= issue & id_mem_read;
      for (int k = 2; k <= DEPTH; k++) begin
        ent_v[k]  <= ent_v[k-1];
        ent_rw[k] <= ent_rw[k-1];
        ent_ld[k] <= ent_ld[k-1];
      end
    end
  end

  // Destination addresses are qualified by ent_v, so they carry no reset.
  always_ff @(posedge clk) begin
    ent_dst[1] <= issue ? id_dst_addr : '0;
    for (int k = 2; k <= DEPTH; k++) begin
      ent_dst[k] <= ent_dst[k-1];
    end
  end

  always_comb begin
    hazard  = 1'b0;
    fwd_sel = '0;
    for (int i = 0; i < NSRC; i++) begin
      int   win_k;
      logic win_ld;
      win_k  = 0;
      win_ld = 1'b0;
      // Scan oldest to youngest so the youngest match is the one that sticks.
      for (int k = MATCH_TOP; k >= 1; k--) begin
        if (id_valid && id_src_used[i] && ent_v[k] && ent_rw[k] &&
            (ent_dst[k] == id_src_addr[i*ADDR_W +: ADDR_W])) begin
          win_k  = k;
          win_ld = ent_ld[k];
        end
      end
      if (win_ld && (win_k < LOAD_STAGE)) begin
        hazard = 1'b1;
      end
      if (!flush_in) begin
        fwd_sel[i*SEL_W +: SEL_W] = SEL_W'(win_k);
      end
    end
    stall = hazard & ~flush_in;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
    end else if (stall) begin
      stall_cnt <= sat_inc(stall_cnt);
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: default build, write-first regfile build,
// and a deeper build with a narrow saturating counter.
module tb_hazard_scoreboard;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Default build
  logic       a_valid, a_rw, a_ld, a_fl;
  logic [5:0] a_src;
  logic [1:0] a_used;
  logic [2:0] a_dst;
  logic       a_stall;
  logic [3:0] a_sel;
  logic [15:0] a_cnt;

  // Write-first regfile build
  logic       b_valid, b_rw, b_ld, b_fl;
  logic [5:0] b_src;
  logic [1:0] b_used;
  logic [2:0] b_dst;
  logic       b_stall;
  logic [3:0] b_sel;
  logic [15:0] b_cnt;

  // ADDR_W=4, DEPTH=4, LOAD_STAGE=3, CNT_W=2
  logic       c_valid, c_rw, c_ld, c_fl;
  logic [7:0] c_src;
  logic [1:0] c_used;
  logic [3:0] c_dst;
  logic       c_stall;
  logic [5:0] c_sel;
  logic [1:0] c_cnt;

  hazard_scoreboard u_a (
    .clk(clk), .rst(rst), .id_valid(a_valid), .id_src_addr(a_src), .id_src_used(a_used),
    .id_dst_addr(a_dst), .id_reg_write(a_rw), .id_mem_read(a_ld), .flush_in(a_fl),
    .stall(a_stall), .fwd_sel(a_sel), .stall_cnt(a_cnt));

  hazard_scoreboard #(.RF_WRITE_FIRST(1)) u_b (
    .clk(clk), .rst(rst), .id_valid(b_valid), .id_src_addr(b_src), .id_src_used(b_used),
    .id_dst_addr(b_dst), .id_reg_write(b_rw), .id_mem_read(b_ld), .flush_in(b_fl),
    .stall(b_stall), .fwd_sel(b_sel), .stall_cnt(b_cnt));

  hazard_scoreboard #(.ADDR_W(4), .DEPTH(4), .LOAD_STAGE(3), .CNT_W(2)) u_c (
    .clk(clk), .rst(rst), .id_valid(c_valid), .id_src_addr(c_src), .id_src_used(c_used),
    .id_dst_addr(c_dst), .id_reg_write(c_rw), .id_mem_read(c_ld), .flush_in(c_fl),
    .stall(c_stall), .fwd_sel(c_sel), .stall_cnt(c_cnt));

  int total = 0;
  int bad   = 0;

  string       q_tag  [$];
  int          q_code [$];
  logic [31:0] q_exp  [$];

  localparam int A_STALL = 0, A_SEL0 = 1, A_SEL1 = 2, A_CNT = 3, B_SEL0 = 4,
                 C_STALL = 5, C_SEL0 = 6, C_CNT = 7, B_STALL = 8;

  function automatic logic [31:0] observe(input int code);
    case (code)
      A_STALL: return 32'(a_stall);
      A_SEL0:  return 32'(a_sel[1:0]);
      A_SEL1:  return 32'(a_sel[3:2]);
      A_CNT:   return 32'(a_cnt);
      B_SEL0:  return 32'(b_sel[1:0]);
      B_STALL: return 32'(b_stall);
      C_STALL: return 32'(c_stall);
      C_SEL0:  return 32'(c_sel[2:0]);
      C_CNT:   return 32'(c_cnt);
      default: return '1;
    endcase
  endfunction

  task automatic push_exp(input string tag, input int code, input logic [31:0] v);
    q_tag.push_back(tag);
    q_code.push_back(code);
    q_exp.push_back(v);
  endtask

  task automatic check_all();
    #1;
    while (q_code.size() > 0) begin
      string       t;
      int          code;
      logic [31:0] e;
      logic [31:0] o;
      t    = q_tag.pop_front();
      code = q_code.pop_front();
      e    = q_exp.pop_front();
      o    = observe(code);
      total++;
      assert (o === e) else begin
        bad++;
        $error("FAIL %s observed=%0d expected=%0d", t, o, e);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_a(input logic v, input logic [2:0] s0, input logic [2:0] s1, input logic [1:0] used,
                       input logic [2:0] dst, input logic rw, input logic ld, input logic fl);
    a_valid = v; a_src = {s1, s0}; a_used = used; a_dst = dst; a_rw = rw; a_ld = ld; a_fl = fl;
  endtask

  task automatic set_b(input logic v, input logic [2:0] s0, input logic [2:0] s1, input logic [1:0] used,
                       input logic [2:0] dst, input logic rw, input logic ld, input logic fl);
    b_valid = v; b_src = {s1, s0}; b_used = used; b_dst = dst; b_rw = rw; b_ld = ld; b_fl = fl;
  endtask

  task automatic set_c(input logic v, input logic [3:0] s0, input logic [3:0] s1, input logic [1:0] used,
                       input logic [3:0] dst, input logic rw, input logic ld, input logic fl);
    c_valid = v; c_src = {s1, s0}; c_used = used; c_dst = dst; c_rw = rw; c_ld = ld; c_fl = fl;
  endtask

  task automatic drain_a();
    set_a(0, 0, 0, 2'b00, 0, 0, 0, 0);
    for (int n = 0; n < 3; n++) tick();
  endtask

  initial begin
    rst = 1'b0;
    set_a(0, 0, 0, 2'b00, 0, 0, 0, 0);
    set_b(0, 0, 0, 2'b00, 0, 0, 0, 0);
    set_c(0, 0, 0, 2'b00, 0, 0, 0, 0);
    #1;
    push_exp("rst_stall", A_STALL, 0);
    push_exp("rst_sel0", A_SEL0, 0);
    push_exp("rst_sel1", A_SEL1, 0);
    push_exp("rst_cnt", A_CNT, 0);
    push_exp("rst_cnt_c", C_CNT, 0);
    check_all();
    tick();
    rst = 1'b1;

    // ALU forwarding from stages 1, 2, 3
    set_a(1, 0, 0, 2'b00, 3, 1, 0, 0);
    push_exp("alu_prod_stall", A_STALL, 0);
    check_all(); tick();
    set_a(1, 3, 3, 2'b01, 3, 0, 0, 0);
    push_exp("alu_fwd1", A_SEL0, 1);
    push_exp("alu_nostall", A_STALL, 0);
    push_exp("unused_operand", A_SEL1, 0);
    check_all(); tick();
    set_a(1, 3, 0, 2'b01, 4, 0, 0, 0);
    push_exp("alu_fwd2_nowrite_skip", A_SEL0, 2);
    check_all(); tick();
    push_exp("alu_fwd3", A_SEL0, 3);
    check_all(); tick();
    push_exp("alu_retired", A_SEL0, 0);
    check_all(); tick();

    // Two operands in different stages, register 0 trackable
    set_a(1, 0, 0, 2'b00, 0, 1, 0, 0); tick();
    set_a(1, 0, 0, 2'b00, 6, 1, 0, 0); tick();
    set_a(1, 6, 0, 2'b11, 1, 0, 0, 0);
    push_exp("two_ops_sel0", A_SEL0, 1);
    push_exp("two_ops_addr0", A_SEL1, 2);
    check_all(); tick();

    // Youngest writer wins
    drain_a();
    set_a(1, 0, 0, 2'b00, 2, 1, 0, 0); tick();
    set_a(1, 0, 0, 2'b00, 1, 1, 0, 0); tick();
    set_a(1, 0, 0, 2'b00, 2, 1, 0, 0); tick();
    set_a(1, 2, 1, 2'b11, 3, 0, 0, 0);
    push_exp("youngest_wins", A_SEL0, 1);
    push_exp("other_op_stage2", A_SEL1, 2);
    check_all(); tick();

    // Load-use: one stall cycle, then forward from stage 2
    drain_a();
    set_a(1, 0, 0, 2'b00, 5, 1, 1, 0);
    push_exp("load_issue_stall", A_STALL, 0);
    check_all(); tick();
    set_a(1, 7, 5, 2'b11, 7, 1, 0, 0);
    push_exp("lu_stall", A_STALL, 1);
    push_exp("lu_sel_during", A_SEL1, 1);
    push_exp("lu_cnt_before", A_CNT, 0);
    check_all(); tick();
    push_exp("lu_release", A_STALL, 0);
    push_exp("lu_fwd2", A_SEL1, 2);
    push_exp("lu_bubble", A_SEL0, 0);
    push_exp("lu_cnt", A_CNT, 1);
    check_all(); tick();
    set_a(1, 7, 0, 2'b01, 0, 0, 0, 0);
    push_exp("lu_consumer_issued", A_SEL0, 1);
    push_exp("lu_cnt_hold", A_CNT, 1);
    check_all(); tick();

    // Flush beats a load-use hazard
    drain_a();
    set_a(1, 0, 0, 2'b00, 5, 1, 1, 0); tick();
    set_a(1, 0, 5, 2'b10, 2, 1, 0, 1);
    push_exp("flush_nostall", A_STALL, 0);
    push_exp("flush_sel1", A_SEL1, 0);
    check_all(); tick();
    set_a(1, 2, 5, 2'b11, 3, 0, 0, 0);
    push_exp("flush_bubble", A_SEL0, 0);
    push_exp("flush_load_stage2", A_SEL1, 2);
    push_exp("flush_cnt_hold", A_CNT, 1);
    check_all();
    set_a(0, 2, 5, 2'b11, 3, 0, 0, 0);
    push_exp("invalid_gate", A_SEL1, 0);
    check_all(); tick();

    // Write-first regfile: stage DEPTH never forwards
    set_b(1, 0, 0, 2'b00, 2, 1, 0, 0); tick();
    set_b(1, 2, 0, 2'b01, 3, 0, 0, 0);
    push_exp("rfwf_stage1", B_SEL0, 1);
    check_all(); tick();
    push_exp("rfwf_stage2", B_SEL0, 2);
    check_all(); tick();
    push_exp("rfwf_stage3_none", B_SEL0, 0);
    push_exp("rfwf_nostall", B_STALL, 0);
    check_all(); tick();

    // Asynchronous reset in the middle of a stall
    drain_a();
    set_a(1, 0, 0, 2'b00, 5, 1, 1, 0); tick();
    set_a(1, 7, 5, 2'b11, 7, 1, 0, 0);
    push_exp("pre_rst_stall", A_STALL, 1);
    check_all();
    rst = 1'b0;
    push_exp("rst_mid_stall", A_STALL, 0);
    push_exp("rst_mid_sel1", A_SEL1, 0);
    push_exp("rst_mid_cnt", A_CNT, 0);
    check_all();
    rst = 1'b1;
    push_exp("post_rst_no_producer", A_SEL1, 0);
    push_exp("post_rst_stall", A_STALL, 0);
    check_all(); tick();
    set_a(1, 7, 0, 2'b01, 0, 0, 0, 0);
    push_exp("post_rst_issue", A_SEL0, 1);
    check_all(); tick();
    set_a(0, 0, 0, 2'b00, 0, 0, 0, 0);

    // Deeper build: two stall cycles, then counter saturation
    set_c(1, 0, 0, 2'b00, 15, 1, 1, 0); tick();
    set_c(1, 15, 0, 2'b01, 1, 0, 0, 0);
    push_exp("c_stall1", C_STALL, 1);
    push_exp("c_sel_s1", C_SEL0, 1);
    check_all(); tick();
    push_exp("c_stall2", C_STALL, 1);
    push_exp("c_sel_s2", C_SEL0, 2);
    push_exp("c_cnt1", C_CNT, 1);
    check_all(); tick();
    push_exp("c_release", C_STALL, 0);
    push_exp("c_fwd3", C_SEL0, 3);
    push_exp("c_cnt2", C_CNT, 2);
    check_all(); tick();
    set_c(1, 0, 0, 2'b00, 14, 1, 1, 0); tick();
    set_c(1, 14, 0, 2'b01, 1, 0, 0, 0);
    push_exp("c_stall3", C_STALL, 1);
    check_all(); tick();
    push_exp("c_cnt3", C_CNT, 3);
    push_exp("c_stall4", C_STALL, 1);
    check_all(); tick();
    push_exp("c_cnt_sat", C_CNT, 3);
    push_exp("c_release2", C_STALL, 0);
    push_exp("c_fwd3_again", C_SEL0, 3);
    check_all(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
